uart_tx_arb: RTL and testbench

Round-robin arbiter and frame sequencer that shares one UART transmit line between two byte requesters. It generates its own bit timing from a clock-cycle divider and serializes each granted byte as start bit, data bits LSB first, then stop bit. It sits between on-chip byte producers and the pad-level tx output.

---
 rtl/uart_tx_arb.sv | 114 +++++++++++
 tb/tb_uart_tx_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter feeding a single UART transmitter.
// Frames are start bit, DATA_WIDTH data bits LSB first, stop bit, CLKS_PER_BIT cycles each.
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif

module uart_tx_arb #(
   parameter int unsigned DATA_WIDTH   = `UART_DATA_WIDTH,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic [1:0]            req_i,
   input  logic [DATA_WIDTH-1:0] data0_i,
   input  logic [DATA_WIDTH-1:0] data1_i,
   output logic [1:0]            ack_o,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t                r_state;
   logic                  r_last;
   logic [CNT_W-1:0]      r_clk_cnt;
   logic [BIT_W-1:0]      r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [1:0]            r_ack;
   logic                  r_done;

   logic                  w_bit_end;
   logic                  w_grant;

   assign w_bit_end = (r_clk_cnt == CNT_LAST);
   // On a tie the requester that was not served last wins.
   assign w_grant   = (req_i == 2'b11) ? ~r_last : req_i[1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_last    <= 1'b1;
         r_clk_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_ack     <= 2'b00;
         r_done    <= 1'b0;
      end else begin
         r_ack  <= 2'b00;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (en_i && (req_i != 2'b00)) begin
                  r_shift   <= w_grant ? data1_i : data0_i;
                  r_last    <= w_grant;
                  r_ack     <= w_grant ? 2'b10 : 2'b01;
                  r_clk_cnt <= '0;
                  r_bit_cnt <= '0;
                  r_state   <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  r_state   <= S_DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  r_shift   <= r_shift >> 1;
                  r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                  if (r_bit_cnt == BIT_LAST) begin
                     r_state <= S_STOP;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  r_done    <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Line level is a pure decode of the registered state and shift register.
   assign tx    = (r_state == S_START) ? 1'b0 :
                  (r_state == S_DATA)  ? r_shift[0] : 1'b1;
   assign busy  = (r_state != S_IDLE);
   assign ack_o = r_ack;
   assign done  = r_done;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized bench for uart_tx_arb: a CLKS_PER_BIT=4 and a CLKS_PER_BIT=1 instance
// checked cycle by cycle against a frame-level reference model.
module tb_uart_tx_arb;

   localparam int unsigned DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_a [2];
   logic          en_a  [2];
   logic [1:0]    req_a [2];
   logic [DW-1:0] d0_a  [2];
   logic [DW-1:0] d1_a  [2];

   logic [1:0] ack4, ack1;
   logic       tx4, tx1, busy4, busy1, done4, done1;

   int m_last [2];
   int n_cmp = 0;
   int n_err = 0;

   uart_tx_arb #(.DATA_WIDTH(DW), .CLKS_PER_BIT(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst_a[0]), .en_i(en_a[0]), .req_i(req_a[0]),
      .data0_i(d0_a[0]), .data1_i(d1_a[0]),
      .ack_o(ack4), .tx(tx4), .busy(busy4), .done(done4)
   );

   uart_tx_arb #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst_a[1]), .en_i(en_a[1]), .req_i(req_a[1]),
      .data0_i(d0_a[1]), .data1_i(d1_a[1]),
      .ack_o(ack1), .tx(tx1), .busy(busy1), .done(done1)
   );

   function automatic int cpb(input int u);
      return (u != 0) ? 1 : 4;
   endfunction

   function automatic logic [1:0] g_ack(input int u);
      return (u != 0) ? ack1 : ack4;
   endfunction
   function automatic logic g_tx(input int u);
      return (u != 0) ? tx1 : tx4;
   endfunction
   function automatic logic g_busy(input int u);
      return (u != 0) ? busy1 : busy4;
   endfunction
   function automatic logic g_done(input int u);
      return (u != 0) ? done1 : done4;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Round-robin reference: sole requester wins, a tie goes to the one not served last.
   function automatic int exp_grant(input int u);
      logic [1:0] r;
      r = req_a[u];
      if (r == 2'b11) return 1 - m_last[u];
      return r[1] ? 1 : 0;
   endfunction

   task automatic idle_check(input int u, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk("idle_ack", g_ack(u), 0);
         chk("idle_busy", g_busy(u), 0);
         chk("idle_tx", g_tx(u), 1);
         chk("idle_done", g_done(u), 0);
      end
   endtask

   // Entered on the negedge where the ack should be visible; returns on the done negedge.
   task automatic frame(input int u, input int g, input bit hold, input int en_drop);
      int c;
      logic [DW+1:0] fb;
      c  = cpb(u);
      fb = {1'b1, ((g != 0) ? d1_a[u] : d0_a[u]), 1'b0};
      chk("ack_grant", g_ack(u), (g != 0) ? 2'b10 : 2'b01);
      if (hold) begin
         if (g != 0) d1_a[u] = DW'($urandom);
         else        d0_a[u] = DW'($urandom);
      end else begin
         req_a[u][g] = 1'b0;
      end
      m_last[u] = g;
      for (int i = 0; i < (DW + 2) * c; i++) begin
         if (i > 0) @(negedge clk);
         if (i == en_drop) en_a[u] = 1'b0;
         chk("tx_bit", g_tx(u), fb[i / c]);
         chk("busy_frame", g_busy(u), 1);
         chk("done_quiet", g_done(u), 0);
         if (i > 0) chk("ack_quiet", g_ack(u), 0);
      end
      @(negedge clk);
      chk("done_pulse", g_done(u), 1);
      chk("done_busy", g_busy(u), 0);
      chk("done_tx", g_tx(u), 1);
      chk("done_ack", g_ack(u), 0);
   endtask

   // Caller has set en and a nonzero req on the current negedge.
   task automatic launch(input int u, input bit hold, input int en_drop);
      int g;
      g = exp_grant(u);
      @(negedge clk);
      frame(u, g, hold, en_drop);
   endtask

   task automatic do_reset(input int u);
      rst_a[u] = 1'b1;
      @(negedge clk);
      rst_a[u] = 1'b0;
      m_last[u] = 1;
   endtask

   initial begin
      logic [1:0] r;
      int gap, drop;
      rst_a = '{1'b1, 1'b1};
      en_a  = '{1'b1, 1'b1};
      req_a = '{2'b00, 2'b00};
      d0_a  = '{8'h00, 8'h00};
      d1_a  = '{8'h00, 8'h00};
      m_last = '{1, 1};
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk("rst_tx", g_tx(u), 1);
         chk("rst_busy", g_busy(u), 0);
         chk("rst_ack", g_ack(u), 0);
         chk("rst_done", g_done(u), 0);
      end
      rst_a = '{1'b0, 1'b0};
      idle_check(0, 2);

      // single request
      d0_a[0] = 8'hA5; req_a[0] = 2'b01;
      launch(0, 1'b0, -1);
      idle_check(0, 2);

      // simultaneous requests after reset: 0 first, then 1 back-to-back
      do_reset(0);
      d0_a[0] = 8'h01; d1_a[0] = 8'h80; req_a[0] = 2'b11;
      launch(0, 1'b0, -1);
      launch(0, 1'b0, -1);
      idle_check(0, 2);

      // fairness with both held, then requester 0 alone back-to-back
      d0_a[0] = DW'($urandom); d1_a[0] = DW'($urandom); req_a[0] = 2'b11;
      repeat (4) launch(0, 1'b1, -1);
      req_a[0] = 2'b01;
      repeat (2) launch(0, 1'b1, -1);
      launch(0, 1'b0, -1);
      idle_check(0, 2);

      // enable gating, then drop enable mid-DATA
      en_a[0] = 1'b0; d0_a[0] = DW'($urandom); req_a[0] = 2'b01;
      idle_check(0, 20);
      en_a[0] = 1'b1;
      launch(0, 1'b0, 3 * cpb(0) + 1);
      en_a[0] = 1'b1;
      idle_check(0, 2);

      // withdrawn request leaves no trace
      en_a[0] = 1'b0; req_a[0] = 2'b10;
      idle_check(0, 3);
      req_a[0] = 2'b00; en_a[0] = 1'b1;
      idle_check(0, 5);

      // reset during data bit 3
      d0_a[0] = DW'($urandom); req_a[0] = 2'b01;
      @(negedge clk);
      chk("rst_mid_ack", ack4, 2'b01);
      req_a[0] = 2'b00;
      repeat (4 * 4 + 1) @(negedge clk);
      chk("rst_mid_bit3", tx4, d0_a[0][3]);
      rst_a[0] = 1'b1;
      @(negedge clk);
      rst_a[0] = 1'b0;
      m_last[0] = 1;
      chk("rst_mid_tx", tx4, 1);
      chk("rst_mid_busy", busy4, 0);
      chk("rst_mid_done", done4, 0);
      chk("rst_mid_ack0", ack4, 0);
      idle_check(0, 3);
      d1_a[0] = DW'($urandom); req_a[0] = 2'b10;
      launch(0, 1'b0, -1);
      idle_check(0, 1);

      // one-cycle-per-bit instance
      d0_a[1] = 8'hFF; req_a[1] = 2'b01;
      launch(1, 1'b0, -1);
      idle_check(1, 1);

      // randomized traffic on each instance in turn
      for (int u = 0; u < 2; u++) begin
         for (int n = 0; n < ((u == 0) ? 30 : 20); n++) begin
            r   = 2'($urandom_range(1, 3));
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
               en_a[u] = 1'b0;
               idle_check(u, gap);
               en_a[u] = 1'b1;
            end
            if (r[0] && !req_a[u][0]) d0_a[u] = DW'($urandom);
            if (r[1] && !req_a[u][1]) d1_a[u] = DW'($urandom);
            req_a[u] = req_a[u] | r;
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (DW + 2) * cpb(u) - 1) : -1;
            launch(u, 1'($urandom_range(0, 1)), drop);
            en_a[u] = 1'b1;
         end
         req_a[u] = 2'b00;
         idle_check(u, 3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
